// File: rtl/smi_frame_arbiter_x3.sv
// smi_frame_arbiter_x3
// Frame-atomic three-way merge of SMI streams A, B and C onto one SMI output.
// Once a frame wins the output it owns it until its end-of-frame flit is moved.
// A single registered output stage gives one-cycle latency with no bubbles
// between back-to-back frames.
//
// Optional feature macro: SMI_FRAME_ARB_FIXED_PRIORITY_EN
//   defined   -> fixed priority A > B > C at each new-frame decision
//   undefined -> round-robin starting after the previous frame's owner

module smi_frame_arbiter_x3 #(
   parameter int FlitWidth = 16,
   parameter int EofcMask  = 2*FlitWidth-1
) (
   input  logic                   clk,
   input  logic                   srst,

   input  logic                   smiInAReady,
   input  logic [7:0]             smiInAEofc,
   input  logic [FlitWidth*8-1:0] smiInAData,
   output logic                   smiInAStop,

   input  logic                   smiInBReady,
   input  logic [7:0]             smiInBEofc,
   input  logic [FlitWidth*8-1:0] smiInBData,
   output logic                   smiInBStop,

   input  logic                   smiInCReady,
   input  logic [7:0]             smiInCEofc,
   input  logic [FlitWidth*8-1:0] smiInCData,
   output logic                   smiInCStop,

   output logic                   smiOutReady,
   output logic [7:0]             smiOutEofc,
   output logic [FlitWidth*8-1:0] smiOutData,
   input  logic                   smiOutStop
);

   localparam int         DataW        = FlitWidth*8;
   localparam logic [7:0] EofcMaskByte = EofcMask[7:0];

   typedef enum logic [1:0] {
      PORT_A    = 2'd0,
      PORT_B    = 2'd1,
      PORT_C    = 2'd2,
      PORT_NONE = 2'd3
   } port_e;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_e;

   function automatic port_e nextPort(input port_e p);
      case (p)
         PORT_A:  return PORT_B;
         PORT_B:  return PORT_C;
         default: return PORT_A;
      endcase
   endfunction

   lock_e             state_q, state_d;
   port_e             owner_q, owner_d;
   port_e             searchStart;
   port_e             grant;
   port_e             cand;
   logic              candReady;

   logic              grantReady;
   logic [7:0]        grantEofc;
   logic [DataW-1:0]  grantData;

   logic              outReady_q;
   logic [7:0]        outEofc_q;
   logic [DataW-1:0]  outData_q;

   logic              outHalt;
   logic              transfer;
   logic              isLast;

`ifdef SMI_FRAME_ARB_FIXED_PRIORITY_EN
   assign searchStart = PORT_A;
`else
   port_e             ptr_q, ptr_d;
   assign searchStart = ptr_q;
`endif

   // A full output register that is being stopped freezes the whole datapath.
   assign outHalt = outReady_q & smiOutStop;

   // Pick the port that may move a flit this cycle: the owner while locked,
   // otherwise the first Ready port walking A->B->C->A from searchStart.
   always_comb begin
      grant     = PORT_NONE;
      cand      = searchStart;
      candReady = 1'b0;
      if (state_q == LOCKED) begin
         grant = owner_q;
      end else begin
         for (int k = 0; k < 3; k++) begin
            case (cand)
               PORT_A:  candReady = smiInAReady;
               PORT_B:  candReady = smiInBReady;
               PORT_C:  candReady = smiInCReady;
               default: candReady = 1'b0;
            endcase
            if ((grant == PORT_NONE) && candReady) begin
               grant = cand;
            end
            cand = nextPort(cand);
         end
      end
   end

   // Route the granted port's flit towards the output register.
   always_comb begin
      grantReady = 1'b0;
      grantEofc  = 8'h00;
      grantData  = '0;
      case (grant)
         PORT_A: begin
            grantReady = smiInAReady;
            grantEofc  = smiInAEofc;
            grantData  = smiInAData;
         end
         PORT_B: begin
            grantReady = smiInBReady;
            grantEofc  = smiInBEofc;
            grantData  = smiInBData;
         end
         PORT_C: begin
            grantReady = smiInCReady;
            grantEofc  = smiInCEofc;
            grantData  = smiInCData;
         end
         default: begin
            grantReady = 1'b0;
         end
      endcase
   end

   // Only a real transfer may change lock ownership or the round-robin pointer.
   assign transfer = grantReady & ~outHalt & ~srst;
   assign isLast   = (grantEofc != 8'h00);

   // Lock on a non-last flit, release on a last flit; a one-flit frame never locks.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (transfer) begin
         if (isLast) begin
            state_d = UNLOCKED;
         end else begin
            state_d = LOCKED;
            owner_d = grant;
         end
      end
   end

`ifdef SMI_FRAME_ARB_FIXED_PRIORITY_EN
`else
   // After a frame completes, the next search begins at the port after its owner.
   always_comb begin
      ptr_d = ptr_q;
      if (transfer && isLast) begin
         ptr_d = nextPort(grant);
      end
   end

   // Round-robin pointer register, restarting at A.
   always_ff @(posedge clk) begin
      if (srst) begin
         ptr_q <= PORT_A;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Lock state and output-valid register; valid holds while the output is halted.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q    <= UNLOCKED;
         owner_q    <= PORT_A;
         outReady_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         if (!outHalt) begin
            outReady_q <= grantReady;
         end
      end
   end

   // Output payload carries no reset; it is qualified by outReady_q.
   always_ff @(posedge clk) begin
      if (!outHalt) begin
         outEofc_q <= grantEofc & EofcMaskByte;
         outData_q <= grantData;
      end
   end

   assign smiInAStop  = srst | outHalt | (grant != PORT_A);
   assign smiInBStop  = srst | outHalt | (grant != PORT_B);
   assign smiInCStop  = srst | outHalt | (grant != PORT_C);

   assign smiOutReady = outReady_q;
   assign smiOutEofc  = outEofc_q;
   assign smiOutData  = outData_q;

endmodule

// File: tb/tb_smi_frame_arbiter_x3.sv
// tb_smi_frame_arbiter_x3
// Directed bench for smi_frame_arbiter_x3 with FlitWidth=16. Each input is
// fed by a small upstream source that advances only on an accepted flit;
// expected output sequences are written out per scenario.

module tb_smi_frame_arbiter_x3;

   localparam int FlitWidth = 16;
   localparam int DW        = FlitWidth*8;

   logic          clk = 1'b0;
   logic          srst;

   logic          inRdy  [3];
   logic [7:0]    inEofc [3];
   logic [DW-1:0] inData [3];
   logic          inStop [3];

   logic          outReady;
   logic [7:0]    outEofc;
   logic [DW-1:0] outData;
   logic          outStop;

   logic          srcActive   [3];
   int            srcLen      [3];
   int            srcIdx      [3];
   int            srcFrame    [3];
   logic [7:0]    srcLastEofc [3];

   int checkCount = 0;
   int failCount  = 0;

   smi_frame_arbiter_x3 #(.FlitWidth(FlitWidth)) dut (
      .clk         (clk),
      .srst        (srst),
      .smiInAReady (inRdy[0]),
      .smiInAEofc  (inEofc[0]),
      .smiInAData  (inData[0]),
      .smiInAStop  (inStop[0]),
      .smiInBReady (inRdy[1]),
      .smiInBEofc  (inEofc[1]),
      .smiInBData  (inData[1]),
      .smiInBStop  (inStop[1]),
      .smiInCReady (inRdy[2]),
      .smiInCEofc  (inEofc[2]),
      .smiInCData  (inData[2]),
      .smiInCStop  (inStop[2]),
      .smiOutReady (outReady),
      .smiOutEofc  (outEofc),
      .smiOutData  (outData),
      .smiOutStop  (outStop)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mkData(input int p, input int f, input int i);
      logic [31:0] w;
      w = {8'hA0 | 8'(p), 8'(f), 8'(i), 8'h5C};
      return {(DW/32){w}};
   endfunction

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic configSrc(input int p, input logic active, input int len,
                            input logic [7:0] lastEofc);
      srcActive[p]   = active;
      srcLen[p]      = len;
      srcIdx[p]      = 0;
      srcFrame[p]    = 0;
      srcLastEofc[p] = lastEofc;
   endtask

   task automatic applyStimulus(input logic [2:0] gate);
      for (int p = 0; p < 3; p++) begin
         inRdy[p]  = srcActive[p] & gate[p];
         inEofc[p] = (srcIdx[p] == srcLen[p]-1) ? srcLastEofc[p] : 8'h00;
         inData[p] = mkData(p, srcFrame[p], srcIdx[p]);
      end
      #1;
   endtask

   task automatic tick();
      logic acc [3];
      for (int p = 0; p < 3; p++) acc[p] = inRdy[p] & ~inStop[p];
      @(posedge clk);
      #1;
      for (int p = 0; p < 3; p++) begin
         if (acc[p]) begin
            srcIdx[p]++;
            if (srcIdx[p] == srcLen[p]) begin
               srcIdx[p] = 0;
               srcFrame[p]++;
            end
         end
      end
   endtask

   task automatic checkStops(input string tag, input logic [2:0] expected);
      checkOutput(tag, DW'({inStop[2], inStop[1], inStop[0]}), DW'(expected));
   endtask

   task automatic expectFlit(input string tag, input int p, input int f, input int i,
                             input logic [7:0] eofc);
      checkOutput({tag, ".rdy"},  DW'(outReady), DW'(1'b1));
      checkOutput({tag, ".data"}, outData, mkData(p, f, i));
      checkOutput({tag, ".eofc"}, DW'(outEofc), DW'(eofc));
   endtask

   task automatic resetDut();
      srst = 1'b1;
      applyStimulus(3'b111);
      tick();
      srst = 1'b0;
   endtask

   initial begin
      int ePort  [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
      int eIdx   [10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
      int eFrame [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      logic [2:0] aGate  [8] = '{3'b111, 3'b111, 3'b101, 3'b101, 3'b111, 3'b111, 3'b111, 3'b111};
      logic [2:0] aStops [8] = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b011, 3'b101};
      int aPort  [8] = '{1, 1, -1, -1, 1, 1, 2, 1};
      int aFrame [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
      int aIdx   [8] = '{0, 1, 0, 0, 2, 3, 0, 0};
      logic [7:0] aEofc [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h00};
      int bIdx   [4] = '{1, 2, 3, 0};
      int bPort  [4] = '{0, 0, 0, 1};
      logic [7:0] bEofc [4] = '{8'h00, 8'h00, 8'h10, 8'h10};
      logic [2:0] bStops [4] = '{3'b110, 3'b110, 3'b110, 3'b101};
`ifdef SMI_FRAME_ARB_FIXED_PRIORITY_EN
      int pPort  [4] = '{0, 0, 0, 0};
      int pFrame [4] = '{0, 1, 2, 3};
`else
      int pPort  [4] = '{0, 2, 0, 2};
      int pFrame [4] = '{0, 0, 1, 1};
`endif

      srst    = 1'b1;
      outStop = 1'b0;

      // Reset with every input Ready and 3-flit frames queued everywhere
      configSrc(0, 1'b1, 3, 8'h10);
      configSrc(1, 1'b1, 3, 8'h10);
      configSrc(2, 1'b1, 3, 8'h10);
      applyStimulus(3'b111);
      checkStops("rst.stops0", 3'b111);
      tick();
      checkOutput("rst.ready0", DW'(outReady), DW'(1'b0));
      applyStimulus(3'b111);
      checkStops("rst.stops1", 3'b111);
      tick();
      checkOutput("rst.ready1", DW'(outReady), DW'(1'b0));
      srst = 1'b0;

      // Contention: A,A,A,B,B,B,C,C,C then the next A frame, no gaps
      for (int k = 0; k < 10; k++) begin
         applyStimulus(3'b111);
         checkStops($sformatf("cont.stops%0d", k), 3'b111 & ~(3'b001 << ePort[k]));
         tick();
         expectFlit($sformatf("cont.flit%0d", k), ePort[k], eFrame[k], eIdx[k],
                    (eIdx[k] == 2) ? 8'h10 : 8'h00);
      end

      // Atomicity: B 4-flit frame pauses after flit 2 while C waits
      configSrc(0, 1'b0, 1, 8'h10);
      configSrc(1, 1'b1, 4, 8'h10);
      configSrc(2, 1'b1, 1, 8'h10);
      resetDut();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(aGate[k]);
         checkStops($sformatf("atom.stops%0d", k), aStops[k]);
         tick();
         if (aPort[k] < 0) begin
            checkOutput($sformatf("atom.gap%0d", k), DW'(outReady), DW'(1'b0));
         end else begin
            expectFlit($sformatf("atom.flit%0d", k), aPort[k], aFrame[k], aIdx[k], aEofc[k]);
         end
      end

      // Backpressure: output stopped for 5 cycles in the middle of A's frame
      configSrc(0, 1'b1, 4, 8'h10);
      configSrc(1, 1'b1, 1, 8'h10);
      configSrc(2, 1'b0, 1, 8'h10);
      resetDut();
      applyStimulus(3'b111);
      checkStops("bp.stopsPre", 3'b110);
      tick();
      expectFlit("bp.first", 0, 0, 0, 8'h00);
      outStop = 1'b1;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(3'b111);
         checkStops($sformatf("bp.haltStops%0d", k), 3'b111);
         tick();
         expectFlit($sformatf("bp.hold%0d", k), 0, 0, 0, 8'h00);
      end
      outStop = 1'b0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(3'b111);
         checkStops($sformatf("bp.stops%0d", k), bStops[k]);
         tick();
         expectFlit($sformatf("bp.flit%0d", k), bPort[k], 0, bIdx[k], bEofc[k]);
      end

      // Eofc mask on a single-flit frame; arbiter must stay unlocked afterwards
      configSrc(0, 1'b1, 1, 8'hFF);
      configSrc(1, 1'b0, 1, 8'h01);
      configSrc(2, 1'b0, 1, 8'h01);
      resetDut();
      applyStimulus(3'b111);
      tick();
      expectFlit("mask.flit", 0, 0, 0, 8'h1F);
      configSrc(0, 1'b0, 1, 8'hFF);
      configSrc(1, 1'b1, 1, 8'h01);
      applyStimulus(3'b111);
      checkStops("mask.unlockedStops", 3'b101);
      tick();
      expectFlit("mask.next", 1, 0, 0, 8'h01);

      // A and C continuously Ready with single-flit frames
      configSrc(0, 1'b1, 1, 8'h10);
      configSrc(1, 1'b0, 1, 8'h10);
      configSrc(2, 1'b1, 1, 8'h10);
      resetDut();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(3'b111);
         tick();
         expectFlit($sformatf("prio.flit%0d", k), pPort[k], pFrame[k], 0, 8'h10);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
